// File: rtl/hfrv_mem_arbiter.sv
// hfrv_mem_arbiter: two-master arbiter/sequencer for a single-port SRAM.
// Serializes one transaction at a time, alternates round-robin under contention,
// honours a bounded ownership lock for read-modify-write, and sequences the SRAM
// strobe and fixed-latency read capture.
module hfrv_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic                  m0_lock,
   output logic                  m0_ack,
   output logic [DATA_W-1:0]     m0_rdata,
   input  logic                  m1_req,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic                  m1_lock,
   output logic                  m1_ack,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  mem_en,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  owner,
   output logic                  busy
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int LCNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(LOCK_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    cnt;
   logic                last_grant;
   logic                lock_hold;   // lock flag of the most recently granted command
   logic [LCNT_W-1:0]   lock_cnt;
   logic                grant;
   logic                winner;
   logic                contested;
   logic                lock_win;
   logic                sel_lock;
   logic [ADDR_W-1:0]   sel_addr;
   logic [STRB_W-1:0]   sel_wstrb;
   logic [DATA_W-1:0]   sel_wdata;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state and arbitration decision; requests only matter in IDLE
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      contested  = m0_req & m1_req;
      // The previous owner keeps the port while its lock budget lasts
      lock_win   = lock_hold & (lock_cnt < LOCK_LIM);
      winner     = m1_req & ~m0_req;
      if (contested) winner = lock_win ? last_grant : ~last_grant;
      sel_addr   = winner ? m1_addr  : m0_addr;
      sel_wstrb  = winner ? m1_wstrb : m0_wstrb;
      sel_wdata  = winner ? m1_wdata : m0_wdata;
      sel_lock   = winner ? m1_lock  : m0_lock;
      case (state)
         S_IDLE: begin
            if (m0_req | m1_req) begin
               grant      = 1'b1;
               state_next = S_ACCESS;
            end
         end
         S_ACCESS: state_next = (mem_wstrb != '0) ? S_DONE : S_WAIT;
         S_WAIT:   if (cnt == '0) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Command capture, ownership and lock bookkeeping on each grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         lock_hold  <= 1'b0;
         lock_cnt   <= '0;
         mem_addr   <= '0;
         mem_wstrb  <= '0;
         mem_wdata  <= '0;
      end else if (grant) begin
         owner      <= winner;
         last_grant <= winner;
         lock_hold  <= sel_lock;
         mem_addr   <= sel_addr;
         mem_wstrb  <= sel_wstrb;
         mem_wdata  <= sel_wdata;
         // Budget resets when ownership moves or the holder releases its lock
         if ((winner != last_grant) || !sel_lock) lock_cnt <= '0;
         else if (contested && lock_win)          lock_cnt <= lock_cnt + LCNT_W'(1);
      end
   end

   // Read latency counter: loaded on the strobe cycle, counts down while waiting
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                cnt <= '0;
      else if (state == S_ACCESS)               cnt <= CNT_LOAD;
      else if (state == S_WAIT && cnt != '0)    cnt <= cnt - CNT_W'(1);
   end

   // Read data capture into the owning master's holding register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (state == S_WAIT && cnt == '0) begin
         if (owner) m1_rdata <= mem_rdata;
         else       m0_rdata <= mem_rdata;
      end
   end

   assign mem_en = (state == S_ACCESS);
   assign m0_ack = (state == S_DONE) & ~owner;
   assign m1_ack = (state == S_DONE) &  owner;
   assign busy   = (state != S_IDLE);

   // A pending command must stay asserted and unchanged until its ack
   a_m0_hold: assert property (@(posedge clk) disable iff (reset)
      (m0_req && !m0_ack) |=> (m0_req && $stable({m0_addr, m0_wstrb, m0_wdata, m0_lock})));
   a_m1_hold: assert property (@(posedge clk) disable iff (reset)
      (m1_req && !m1_ack) |=> (m1_req && $stable({m1_addr, m1_wstrb, m1_wdata, m1_lock})));

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Bench for hfrv_mem_arbiter: SRAM model with fixed read latency, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_hfrv_mem_arbiter;
   localparam int RD_LAT   = 3;
   localparam int LOCK_MAX = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        req = '0;
   logic [1:0][31:0]  addr = '0;
   logic [1:0][3:0]   wstrb = '0;
   logic [1:0][31:0]  wdata = '0;
   logic [1:0]        lock = '0;
   logic [1:0]        ack;
   logic [1:0][31:0]  rdata;
   logic              mem_en;
   logic [31:0]       mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              owner;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int order[$];
   int strobe_cycles = 0;

   always #5 clk = ~clk;

   hfrv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_addr(addr[0]), .m0_wstrb(wstrb[0]), .m0_wdata(wdata[0]),
      .m0_lock(lock[0]), .m0_ack(ack[0]), .m0_rdata(rdata[0]),
      .m1_req(req[1]), .m1_addr(addr[1]), .m1_wstrb(wstrb[1]), .m1_wdata(wdata[1]),
      .m1_lock(lock[1]), .m1_ack(ack[1]), .m1_rdata(rdata[1]),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SRAM: byte-masked writes, read data appears RD_LAT cycles after the strobe cycle;
   // between reads the pipe carries junk so a mistimed capture is visible
   logic [31:0] sram [256] = '{default: 32'h0};
   logic [31:0] pipe [RD_LAT] = '{default: 32'h0};
   assign mem_rdata = pipe[RD_LAT-1];
   always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= 32'hBAD0_0000 | 32'(cyc);
      if (mem_en) begin
         if (mem_wstrb == 4'b0000) pipe[0] <= sram[mem_addr[9:2]];
         else for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   always @(negedge clk) if (mem_en && mem_wstrb == 4'b0010) strobe_cycles++;

   // Reference model: one transaction record with its grant cycle; all outputs follow
   // from the grant cycle and the fixed write/read durations
   logic        m_have = 1'b0;
   int          m_g = 0;
   int          m_len = 0;
   logic        m_w = 1'b0;
   logic        m_wr = 1'b0;
   logic        m_last = 1'b1;
   logic        m_lock_hold = 1'b0;
   int          m_lock_cnt = 0;
   logic        e_owner = 1'b0;
   logic [31:0] e_addr = '0;
   logic [3:0]  e_wstrb = '0;
   logic [31:0] e_wdata = '0;
   logic [31:0] e_rdata [2] = '{default: 32'h0};
   logic [31:0] m_rd_val = '0;
   logic [31:0] ref_mem [256] = '{default: 32'h0};
   logic        lk_ok;
   int          w;
   logic [7:0]  idx;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("rst_ctrl", {27'b0, mem_en, ack, owner, busy}, 32'h0);
         chk("rst_mem_addr", mem_addr, 32'h0);
         chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
         chk("rst_mem_wdata", mem_wdata, 32'h0);
         chk("rst_rdata0", rdata[0], 32'h0);
         chk("rst_rdata1", rdata[1], 32'h0);
         m_have = 1'b0; m_last = 1'b1; m_lock_hold = 1'b0; m_lock_cnt = 0;
         e_owner = 1'b0; e_addr = '0; e_wstrb = '0; e_wdata = '0;
         e_rdata[0] = '0; e_rdata[1] = '0;
      end else begin
         if (m_have && !m_wr && cyc == m_g + m_len) e_rdata[m_w] = m_rd_val;
         chk("busy", {31'b0, busy}, {31'b0, m_have && cyc > m_g && cyc <= m_g + m_len});
         chk("mem_en", {31'b0, mem_en}, {31'b0, m_have && cyc == m_g + 1});
         chk("ack0", {31'b0, ack[0]}, {31'b0, m_have && cyc == m_g + m_len && !m_w});
         chk("ack1", {31'b0, ack[1]}, {31'b0, m_have && cyc == m_g + m_len && m_w});
         chk("ack_both", {31'b0, &ack}, 32'h0);
         chk("owner", {31'b0, owner}, {31'b0, e_owner});
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_wstrb});
         chk("mem_wdata", mem_wdata, e_wdata);
         chk("rdata0", rdata[0], e_rdata[0]);
         chk("rdata1", rdata[1], e_rdata[1]);
         // Arbitrate when the port is free and someone is asking
         if ((!m_have || cyc > m_g + m_len) && req != 2'b00) begin
            lk_ok = m_lock_hold && (m_lock_cnt < LOCK_MAX);
            if (req == 2'b11) w = lk_ok ? int'(m_last) : int'(!m_last);
            else              w = req[1] ? 1 : 0;
            if (w != int'(m_last) || !lock[w]) m_lock_cnt = 0;
            else if (req == 2'b11 && lk_ok)     m_lock_cnt = m_lock_cnt + 1;
            m_last = w[0]; m_lock_hold = lock[w];
            m_w = w[0]; e_owner = w[0];
            e_addr = addr[w]; e_wstrb = wstrb[w]; e_wdata = wdata[w];
            m_wr = (wstrb[w] != 4'b0000);
            m_len = m_wr ? 2 : RD_LAT + 2;
            m_g = cyc; m_have = 1'b1;
            idx = addr[w][9:2];
            if (m_wr) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[w][b]) ref_mem[idx][8*b +: 8] = wdata[w][8*b +: 8];
            end else m_rd_val = ref_mem[idx];
         end
      end
   end

   // Issue n commands from master m back to back; records ack order, latency and busy cycles
   task automatic run_master(input int m, input int n, input logic [31:0] base,
                             input logic [3:0] st, input logic [31:0] wd, input logic lk,
                             output int lat, output int busy_n);
      lat = 0; busy_n = 0;
      for (int i = 0; i < n; i++) begin
         req[m] = 1'b1; addr[m] = base + 32'(4 * i); wstrb[m] = st;
         wdata[m] = wd + 32'(i); lock[m] = lk;
         lat = 0; busy_n = 0;
         @(negedge clk);
         while (!ack[m] && lat < 60) begin
            if (busy) busy_n++;
            lat++;
            @(negedge clk);
         end
         if (busy) busy_n++;
         chk($sformatf("ack_seen_m%0d", m), {31'b0, ack[m]}, 32'h1);
         if (ack[m]) order.push_back(m);
         @(posedge clk); #1;
      end
      req[m] = 1'b0;
   endtask

   function automatic logic [31:0] pack_order();
      logic [31:0] v = '0;
      for (int i = 0; i < order.size() && i < 32; i++) v[i] = order[i][0];
      return v;
   endfunction

   int lat, bn, l1, b1;

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // 1: single write from m0
      run_master(0, 1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b0, lat, bn);
      chk("t1_ack_latency", 32'(lat), 32'd2);
      chk("t1_busy_cycles", 32'(bn), 32'd2);
      chk("t1_mem_addr", mem_addr, 32'h40);
      chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t1_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);

      // 2: read back from m1 with RD_LAT=3
      run_master(1, 1, 32'h40, 4'h0, 32'h0, 1'b0, lat, bn);
      chk("t2_ack_latency", 32'(lat), 32'd5);
      chk("t2_busy_cycles", 32'(bn), 32'd5);
      chk("t2_m1_rdata", rdata[1], 32'hDEADBEEF);
      chk("t2_m0_rdata", rdata[0], 32'h0);

      // 3: both masters read continuously from reset
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      order.delete();
      fork
         run_master(0, 2, 32'h3C, 4'h0, 32'h0, 1'b0, lat, bn);
         run_master(1, 2, 32'h3C, 4'h0, 32'h0, 1'b0, l1, b1);
      join
      chk("t3_order_len", 32'(order.size()), 32'd4);
      chk("t3_order", pack_order(), 32'b1010);
      chk("t3_m0_rdata", rdata[0], 32'hDEADBEEF);
      chk("t3_m1_rdata", rdata[1], 32'hDEADBEEF);

      // 4: m0 locked writes against a waiting m1
      order.delete();
      fork
         run_master(0, 6, 32'h80, 4'hF, 32'h1000, 1'b1, lat, bn);
         run_master(1, 1, 32'h100, 4'hF, 32'h2000, 1'b0, l1, b1);
      join
      chk("t4_order_len", 32'(order.size()), 32'd7);
      chk("t4_order", pack_order(), 32'b0100000);

      // 5: reset during the wait phase of a read, then a fresh tie
      req[0] = 1'b1; addr[0] = 32'h40; wstrb[0] = 4'h0; wdata[0] = 32'h0; lock[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t5_busy_in_reset", {31'b0, busy}, 32'h0);
      chk("t5_ack_in_reset", {30'b0, ack}, 32'h0);
      chk("t5_m1_rdata_cleared", rdata[1], 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      order.delete();
      fork
         run_master(0, 1, 32'h40, 4'h0, 32'h0, 1'b0, lat, bn);
         run_master(1, 1, 32'h84, 4'h0, 32'h0, 1'b0, l1, b1);
      join
      chk("t5_order", pack_order(), 32'b10);
      chk("t5_m0_rdata", rdata[0], 32'hDEADBEEF);
      chk("t5_m1_rdata", rdata[1], 32'h1001);

      // 6: single-byte strobe write merges into existing word
      run_master(0, 1, 32'h44, 4'hF, 32'h12345678, 1'b0, lat, bn);
      strobe_cycles = 0;
      run_master(0, 1, 32'h44, 4'b0010, 32'h0000AB00, 1'b0, lat, bn);
      chk("t6_strobe_cycles", 32'(strobe_cycles), 32'd1);
      run_master(1, 1, 32'h44, 4'h0, 32'h0, 1'b0, lat, bn);
      chk("t6_m1_rdata", rdata[1], 32'h1234AB78);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
